// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter. Port 0 (pipeline MEM stage) has priority and port 1
// (loader/debug) is protected from starvation. One memory access is issued every three cycles.
//
// state  | meaning
// IDLE   | arbitrate and latch the winning command
// ACCESS | drive memory strobes for the latched command, gnt of the winning port high
// RESP   | done/err pulse, read data returned and captured
module dmem_arbiter #(
    parameter logic [31:0] BASE         = 32'h0010_0000,
    parameter int unsigned DEPTH        = 5,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,

    input  logic        req0_i,
    input  logic        we0_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] wdata0_i,
    output logic        gnt0_o,
    output logic        done0_o,
    output logic        err0_o,
    output logic [31:0] rdata0_o,

    input  logic        req1_i,
    input  logic        we1_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata1_i,
    output logic        gnt1_o,
    output logic        done1_o,
    output logic        err1_o,
    output logic [31:0] rdata1_o,

    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int unsigned      CNT_W    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
    // 33-bit bounds so BASE+DEPTH cannot wrap; ADDR_END is exclusive.
    localparam logic [32:0]      ADDR_LO  = {1'b0, BASE};
    localparam logic [32:0]      ADDR_END = {1'b0, BASE} + 33'(DEPTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic             cmd_port_q, cmd_port_d;
    logic             cmd_we_q, cmd_we_d;
    logic             cmd_hit_q, cmd_hit_d;
    logic [31:0]      cmd_addr_q, cmd_addr_d;
    logic [31:0]      cmd_wdata_q, cmd_wdata_d;

    logic [31:0]      rdata0_q, rdata0_d;
    logic [31:0]      rdata1_q, rdata1_d;

    logic             any_req;
    logic             win1;
    logic [31:0]      addr_sel;
    logic             sel_hit;
    logic [31:0]      resp_rdata;

    assign any_req    = req0_i | req1_i;
    assign win1       = req1_i & (~req0_i | (starve_q == CNT_MAX));
    assign addr_sel   = win1 ? addr1_i : addr0_i;
    assign sel_hit    = ({1'b0, addr_sel} >= ADDR_LO) && ({1'b0, addr_sel} < ADDR_END);
    assign resp_rdata = cmd_hit_q ? mem_rdata_i : 32'h0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d    = starve_q;
        cmd_port_d  = cmd_port_q;
        cmd_we_d    = cmd_we_q;
        cmd_hit_d   = cmd_hit_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        if (state_q == IDLE) begin
            if (any_req) begin
                cmd_port_d  = win1;
                cmd_we_d    = win1 ? we1_i : we0_i;
                cmd_addr_d  = addr_sel;
                cmd_wdata_d = win1 ? wdata1_i : wdata0_i;
                cmd_hit_d   = sel_hit;
            end
            // Counter only tracks port-0 wins that made a waiting port 1 wait longer.
            if (win1 || !req1_i) begin
                starve_d = '0;
            end else if (starve_q != CNT_MAX) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end

        if (state_q == RESP && !cmd_we_q) begin
            if (cmd_port_q) begin
                rdata1_d = resp_rdata;
            end else begin
                rdata0_d = resp_rdata;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_q    <= '0;
            cmd_port_q  <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_hit_q   <= 1'b0;
            cmd_addr_q  <= 32'h0;
            cmd_wdata_q <= 32'h0;
            rdata0_q    <= 32'h0;
            rdata1_q    <= 32'h0;
        end else begin
            starve_q    <= starve_d;
            cmd_port_q  <= cmd_port_d;
            cmd_we_q    <= cmd_we_d;
            cmd_hit_q   <= cmd_hit_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    always_comb begin
        gnt0_o      = 1'b0;
        gnt1_o      = 1'b0;
        done0_o     = 1'b0;
        done1_o     = 1'b0;
        err0_o      = 1'b0;
        err1_o      = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        rdata0_o    = rdata0_q;
        rdata1_o    = rdata1_q;

        case (state_q)
            ACCESS: begin
                gnt0_o      = ~cmd_port_q;
                gnt1_o      = cmd_port_q;
                mem_read_o  = ~cmd_we_q & cmd_hit_q;
                mem_write_o = cmd_we_q & cmd_hit_q;
                mem_addr_o  = cmd_addr_q;
                mem_wdata_o = cmd_wdata_q;
            end
            RESP: begin
                // A reset landing in RESP aborts the transaction, so suppress its completion.
                if (!reset_i) begin
                    done0_o = ~cmd_port_q;
                    done1_o = cmd_port_q;
                    err0_o  = ~cmd_port_q & ~cmd_hit_q;
                    err1_o  = cmd_port_q & ~cmd_hit_q;
                end
                if (!cmd_we_q) begin
                    if (cmd_port_q) begin
                        rdata1_o = resp_rdata;
                    end else begin
                        rdata0_o = resp_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    a_one_grant: assert property (@(posedge clk_i) !(gnt0_o && gnt1_o));
    a_one_strobe: assert property (@(posedge clk_i) !(mem_read_o && mem_write_o));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic, all outputs compared
// every cycle against a transaction-level reference model with its own memory image.
module tb_dmem_arbiter;

    localparam logic [31:0] BASE  = 32'h0010_0000;
    localparam int          DEPTH = 5;
    localparam int          LIMIT = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req, we, gnt, done, err;
    logic [1:0][31:0] addr, wdata, rdata;
    logic             mem_read, mem_write;
    logic [31:0]      mem_addr, mem_wdata;
    logic [31:0]      mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.BASE(BASE), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .req0_i     (req[0]),
        .we0_i      (we[0]),
        .addr0_i    (addr[0]),
        .wdata0_i   (wdata[0]),
        .gnt0_o     (gnt[0]),
        .done0_o    (done[0]),
        .err0_o     (err[0]),
        .rdata0_o   (rdata[0]),
        .req1_i     (req[1]),
        .we1_i      (we[1]),
        .addr1_i    (addr[1]),
        .wdata1_i   (wdata[1]),
        .gnt1_o     (gnt[1]),
        .done1_o    (done[1]),
        .err1_o     (err[1]),
        .rdata1_o   (rdata[1]),
        .mem_read_o (mem_read),
        .mem_write_o(mem_write),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    function automatic bit in_rng(logic [31:0] a);
        return (64'(a) >= 64'(BASE)) && (64'(a) < 64'(BASE) + 64'(DEPTH));
    endfunction

    function automatic int idx_of(logic [31:0] a);
        return int'(a - BASE);
    endfunction

    // Data memory attached to the DUT: synchronous read, write on strobe.
    logic [31:0] dmem [DEPTH] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_write && in_rng(mem_addr)) dmem[idx_of(mem_addr)] <= mem_wdata;
        if (mem_read && in_rng(mem_addr)) mem_rdata <= dmem[idx_of(mem_addr)];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: phase of the single in-flight transaction, its command, starvation count.
    int               m_phase;
    int               m_port;
    logic             m_we;
    logic [31:0]      m_addr, m_wdata;
    int               m_starve;
    logic [1:0][31:0] m_rdata;
    logic [31:0]      mref [DEPTH] = '{default: 32'h0};

    // Requester bookkeeping: 0 idle, 1 waiting for grant, 2 granted, waiting for done.
    int  rq_st [2];
    int  auto_rate = 0;
    int  rst_rate  = 0;
    bit  scramble  = 0;
    bit  recording = 0;
    bit  rst_now   = 0;
    int  gseq [$];

    task automatic check_outputs();
        logic [7:0]       f_exp, f_got;
        logic [31:0]      e_addr, e_wdata;
        logic [1:0][31:0] e_rd;
        bit               hit;
        hit     = in_rng(m_addr);
        f_exp   = '0;
        e_addr  = '0;
        e_wdata = '0;
        e_rd    = m_rdata;
        if (m_phase == 1) begin
            f_exp[m_port] = 1'b1;
            f_exp[6]      = hit & ~m_we;
            f_exp[7]      = hit & m_we;
            e_addr        = m_addr;
            e_wdata       = m_wdata;
        end else if (m_phase == 2) begin
            f_exp[2 + m_port] = 1'b1;
            f_exp[4 + m_port] = ~hit;
            if (!m_we) e_rd[m_port] = hit ? mref[idx_of(m_addr)] : 32'h0;
        end
        f_got = {mem_write, mem_read, err, done, gnt};
        check_eq("flags{wr,rd,err,done,gnt}", 32'(f_got), 32'(f_exp));
        check_eq("mem_addr", mem_addr, e_addr);
        check_eq("mem_wdata", mem_wdata, e_wdata);
        check_eq("rdata0", rdata[0], e_rd[0]);
        check_eq("rdata1", rdata[1], e_rd[1]);
    endtask

    task automatic observe();
        for (int p = 0; p < 2; p++) begin
            if (gnt[p]) begin
                rq_st[p] = 2;
                if (recording) gseq.push_back(p);
                if (scramble && $urandom_range(1) == 1) begin
                    addr[p]  = $urandom;
                    wdata[p] = $urandom;
                    we[p]    = 1'($urandom);
                    req[p]   = 1'($urandom);
                end
            end
            if (done[p]) begin
                rq_st[p] = 0;
                req[p]   = 1'b0;
            end
        end
    endtask

    task automatic new_tx(int p, logic w, logic [31:0] a, logic [31:0] d);
        req[p]   = 1'b1;
        we[p]    = w;
        addr[p]  = a;
        wdata[p] = d;
        rq_st[p] = 1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(19);
        if (r == 0) return $urandom;
        if (r == 1) return 32'hFFFF_FFFF;
        return BASE - 32'd2 + 32'($urandom_range(DEPTH + 3));
    endfunction

    task automatic model_advance();
        int w;
        // A write strobe already on the bus lands in memory even if reset aborts the transaction.
        if (m_phase == 1 && m_we && in_rng(m_addr)) mref[idx_of(m_addr)] = m_wdata;
        if (reset) begin
            m_phase  = 0;
            m_starve = 0;
            m_rdata  = '0;
            m_port   = 0;
            m_we     = 1'b0;
            m_addr   = '0;
            m_wdata  = '0;
            return;
        end
        case (m_phase)
            0: begin
                if (req[0] || req[1]) begin
                    if (!req[0]) w = 1;
                    else if (req[1] && m_starve == LIMIT) w = 1;
                    else w = 0;
                    if (w == 1 || !req[1]) m_starve = 0;
                    else if (m_starve < LIMIT) m_starve++;
                    m_port  = w;
                    m_we    = we[w];
                    m_addr  = addr[w];
                    m_wdata = wdata[w];
                    m_phase = 1;
                end else begin
                    m_starve = 0;
                end
            end
            1: m_phase = 2;
            default: begin
                if (!m_we) m_rdata[m_port] = in_rng(m_addr) ? mref[idx_of(m_addr)] : 32'h0;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic tick_check();
        @(negedge clk);
        check_outputs();
        observe();
    endtask

    task automatic tick_adv();
        bit do_rst;
        do_rst  = rst_now || (rst_rate > 0 && $urandom_range(rst_rate - 1) == 0);
        rst_now = 0;
        for (int p = 0; p < 2; p++) begin
            if (rq_st[p] == 0 && auto_rate > 0 && $urandom_range(99) < auto_rate)
                new_tx(p, 1'($urandom), rand_addr(), $urandom);
        end
        reset = do_rst;
        if (do_rst) begin
            for (int p = 0; p < 2; p++) begin
                if (rq_st[p] == 2) begin
                    rq_st[p] = 0;
                    req[p]   = 1'b0;
                end
            end
        end
        model_advance();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            tick_check();
            tick_adv();
        end
    endtask

    int exp_seq [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

    initial begin
        reset    = 1'b1;
        req      = '0;
        we       = '0;
        addr     = '0;
        wdata    = '0;
        rq_st[0] = 0;
        rq_st[1] = 0;
        m_phase  = 0;
        m_port   = 0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_starve = 0;
        m_rdata  = '0;
        repeat (2) @(posedge clk);

        // Reset state, then release.
        tick_check();
        tick_adv();

        // Seed DEADBEEF through port 1, then read it back on port 0.
        tick_check();
        new_tx(1, 1'b1, BASE + 32'd2, 32'hDEADBEEF);
        tick_adv();
        run(3);
        tick_check();
        new_tx(0, 1'b0, BASE + 32'd2, 32'h0);
        tick_adv();
        tick_check();
        check_eq("rd0_gnt_latency", 32'({gnt, mem_read}), 32'b011);
        tick_adv();
        tick_check();
        check_eq("rd0_done_latency", 32'({done, err}), 32'b0100);
        check_eq("rd0_data_resp", rdata[0], 32'hDEADBEEF);
        tick_adv();
        run(2);
        check_eq("rd0_data_held", rdata[0], 32'hDEADBEEF);

        // Port-1 write then read back.
        tick_check();
        new_tx(1, 1'b1, BASE + 32'd4, 32'h12345678);
        tick_adv();
        run(3);
        tick_check();
        new_tx(1, 1'b0, BASE + 32'd4, 32'h0);
        tick_adv();
        run(3);
        check_eq("rd1_back", rdata[1], 32'h12345678);

        // Just past the top of the window: error, no strobe, zero data.
        tick_check();
        new_tx(0, 1'b0, BASE + 32'd5, 32'h0);
        tick_adv();
        run(1);
        tick_check();
        check_eq("oor_err0", 32'({done[0], err[0]}), 32'b11);
        tick_adv();
        run(1);
        check_eq("oor_rdata0", rdata[0], 32'h0);

        // Both ports requesting continuously: starvation limit forces every fourth grant to port 1.
        auto_rate = 100;
        recording = 1;
        run(24);
        auto_rate = 0;
        recording = 0;
        run(10);
        check_eq("gseq_len_ge8", 32'(gseq.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < gseq.size(); i++)
            check_eq($sformatf("gseq[%0d]", i), 32'(gseq[i]), 32'(exp_seq[i]));

        // Reset during a port-0 write with port 1 pending.
        tick_check();
        new_tx(0, 1'b1, BASE + 32'd1, 32'hAAAA5555);
        new_tx(1, 1'b0, BASE + 32'd1, 32'h0);
        tick_adv();
        tick_check();
        check_eq("rst_pre_gnt", 32'(gnt), 32'b01);
        rst_now = 1;
        tick_adv();
        tick_check();
        check_eq("rst_outputs_zero", 32'({done, err, gnt, mem_read, mem_write}), 32'h0);
        tick_adv();
        tick_check();
        check_eq("post_rst_gnt1", 32'(gnt), 32'b10);
        tick_adv();
        run(3);

        // Port 0 drops req after the grant; completion still happens and data is held.
        tick_check();
        new_tx(0, 1'b0, BASE + 32'd3, 32'h0);
        tick_adv();
        tick_check();
        req[0] = 1'b0;
        tick_adv();
        tick_check();
        check_eq("drop_done0", 32'(done), 32'b01);
        tick_adv();
        run(3);
        check_eq("drop_rdata_held", rdata[0], mref[3]);

        // Random traffic with scrambled post-grant inputs and occasional resets.
        auto_rate = 40;
        scramble  = 1;
        rst_rate  = 150;
        run(3000);
        auto_rate = 0;
        rst_rate  = 0;
        scramble  = 0;
        run(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
